// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_pkg
//  Purpose  : Shared definitions for the push-button command front end:
//             button ids, repeat FSM state encoding and the command entry
//             width helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package btn_pkg;

  // Board button ids
  localparam int BTN_CENTER = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 4;

  localparam int NUM_BTN_BOARD = 5;
  localparam int ID_W_BOARD    = $clog2(NUM_BTN_BOARD);

  // Command entry width for a given button count: {rpt, id}
  function automatic int cmd_w(input int num_btn);
    return $clog2(num_btn) + 1;
  endfunction

  localparam int CMD_W = cmd_w(NUM_BTN_BOARD);

  // Auto-repeat owner state
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

endpackage
`default_nettype wire

// File: rtl/btn_cmd_scheduler_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_fifo
//  Purpose  : Small synchronous FIFO holding button commands.
//             Head is presented combinationally and held stable until read.
//  Ports    : clk, rst       clock, asynchronous active-high reset
//             wr_en_i        push wr_data_i (accepted if not full, or if a
//                            read happens in the same clk)
//             rd_en_i        pop head when valid_o
//             full_o         all DEPTH entries occupied
//             valid_o        head entry present
//             rd_data_o      head entry (zero when empty)
//  Revision : 1.0  initial release
// ============================================================================
module cmd_fifo #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             w_empty, w_do_rd, w_do_wr;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o = ~w_empty;

  assign w_do_rd = rd_en_i & ~w_empty;
  assign w_do_wr = wr_en_i & (~full_o | w_do_rd);

  assign rd_data_o = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (w_do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only visible behind the pointers.
  always_ff @(posedge clk) begin
    if (w_do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/btn_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : btn_cmd_scheduler
//  Purpose  : Push-button front end. Shared sample tick, 3-bit history
//             debounce/edge detect per button, single-owner auto-repeat,
//             round-robin arbitration of pending events into a command FIFO.
//  Ports    : clk, rst       clock, asynchronous active-high reset
//             btn_raw_i      raw button levels (sampled only on tick)
//             tick_o         1-clk sample enable, every 2^DIV_W clk
//             btn_level_o    debounced levels
//             cmd_valid_o    FIFO head valid
//             cmd_ready_i    consumer accepts head
//             cmd_id_o       head button id
//             cmd_rpt_o      head is an auto-repeat (0 = fresh press)
//             overflow_o     sticky: an event was merged into a pending one
//  Revision : 1.0  initial release
// ============================================================================
module btn_cmd_scheduler
  import btn_pkg::*;
#(
  parameter  int                 NUM_BTN     = 5,
  parameter  int                 DIV_W       = 17,
  parameter  logic [NUM_BTN-1:0] REPEAT_MASK = 5'b11110,
  parameter  int                 REPEAT_DLY  = 384,
  parameter  int                 REPEAT_RATE = 76,
  parameter  int                 FIFO_DEPTH  = 4,
  localparam int                 ID_W        = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  output logic               tick_o,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic [ID_W-1:0]    cmd_id_o,
  output logic               cmd_rpt_o,
  output logic               overflow_o
);

  localparam int ENTRY_W = cmd_w(NUM_BTN);
  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // ---------------------------------------------------------------- divider
  logic [DIV_W-1:0] div_q;
  logic             tick_q, tick_dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      tick_dly_q <= 1'b0;
    end else begin
      div_q      <= div_q + DIV_W'(1);
      tick_q     <= &div_q;       // registered carry-out
      tick_dly_q <= tick_q;       // edge detection runs the clk after tick
    end
  end

  assign tick_o = tick_q;

  // ------------------------------------------------------------- histories
  // hist[2] is the newest sample; hist[1] is the debounced level.
  logic [2:0]         hist_q [NUM_BTN];
  logic [NUM_BTN-1:0] w_level, w_press, w_release;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) hist_q[i] <= '0;
    end else if (tick_q) begin
      for (int i = 0; i < NUM_BTN; i++) hist_q[i] <= {btn_raw_i[i], hist_q[i][2:1]};
    end
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    assign w_level[gi]   = hist_q[gi][1];
    assign w_press[gi]   = tick_dly_q &  hist_q[gi][1] & ~hist_q[gi][0];
    assign w_release[gi] = tick_dly_q & ~hist_q[gi][1] &  hist_q[gi][0];
  end

  assign btn_level_o = w_level;

  // ------------------------------------------------------------- repeat FSM
  rpt_state_e         st_q, st_d;
  logic [ID_W-1:0]    own_q, own_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_BTN-1:0] w_rpt_evt;
  logic               w_new_hit;
  logic [ID_W-1:0]    w_new_id;

  // Lowest-index masked press that is not the current owner takes ownership.
  always_comb begin
    w_new_hit = 1'b0;
    w_new_id  = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_press[i] && REPEAT_MASK[i] &&
          ((st_q == RPT_IDLE) || (own_q != ID_W'(i)))) begin
        w_new_hit = 1'b1;
        w_new_id  = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= RPT_IDLE;
      own_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    own_d     = own_q;
    cnt_d     = cnt_q;
    w_rpt_evt = '0;
    if (tick_dly_q) begin
      if (w_new_hit) begin
        st_d  = RPT_DELAY;
        own_d = w_new_id;
        cnt_d = CNT_W'(REPEAT_DLY);
      end else if (st_q != RPT_IDLE) begin
        // Release is checked before expiry so it suppresses a due repeat.
        if (w_release[own_q] || !w_level[own_q]) begin
          st_d = RPT_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          w_rpt_evt[own_q] = 1'b1;
          cnt_d            = CNT_W'(REPEAT_RATE);
          st_d             = RPT_REPEAT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  // ------------------------------------------------------ pending / arbiter
  logic [NUM_BTN-1:0] pend_q, pend_d, pend_rpt_q, pend_rpt_d, w_evt, w_grant;
  logic [ID_W-1:0]    rr_q, rr_d, w_gnt_id;
  logic               w_gnt_any, ovf_q, ovf_d, w_fifo_full;

  assign w_evt = w_press | w_rpt_evt;

  always_comb begin : arbiter
    logic [ID_W:0] idx;
    w_grant   = '0;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    idx       = '0;
    if (!w_fifo_full) begin
      for (int k = 0; k < NUM_BTN; k++) begin
        idx = {1'b0, rr_q} + (ID_W+1)'(k);
        if (idx >= (ID_W+1)'(NUM_BTN)) idx = idx - (ID_W+1)'(NUM_BTN);
        if (!w_gnt_any && pend_q[idx[ID_W-1:0]]) begin
          w_gnt_any = 1'b1;
          w_gnt_id  = idx[ID_W-1:0];
        end
      end
    end
    if (w_gnt_any) w_grant[w_gnt_id] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (w_gnt_any) rr_d = (w_gnt_id == ID_W'(NUM_BTN - 1)) ? '0 : w_gnt_id + ID_W'(1);
  end

  // A new event on a still-ungranted pending bit is merged (overflow);
  // a press always clears the repeat flag.
  always_comb begin
    pend_d     = pend_q;
    pend_rpt_d = pend_rpt_q;
    ovf_d      = ovf_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (w_evt[i]) begin
        if (pend_q[i] && !w_grant[i]) begin
          ovf_d         = 1'b1;
          pend_rpt_d[i] = pend_rpt_q[i] & ~w_press[i];
        end else begin
          pend_rpt_d[i] = ~w_press[i];
        end
        pend_d[i] = 1'b1;
      end else if (w_grant[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      pend_rpt_q <= '0;
      rr_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_rpt_q <= pend_rpt_d;
      rr_q       <= rr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;

  // ------------------------------------------------------------------ FIFO
  logic [ENTRY_W-1:0] w_head;

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (w_gnt_any),
    .wr_data_i ({pend_rpt_q[w_gnt_id], w_gnt_id}),
    .rd_en_i   (cmd_ready_i),
    .full_o    (w_fifo_full),
    .valid_o   (cmd_valid_o),
    .rd_data_o (w_head)
  );

  assign cmd_rpt_o = w_head[ID_W];
  assign cmd_id_o  = w_head[ID_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_btn_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_cmd_scheduler
//  Purpose  : Self-checking bench for btn_cmd_scheduler with fast sim params.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_cmd_scheduler;
  import btn_pkg::*;

  localparam int             NB    = 5;
  localparam int             DIVP  = 16;
  localparam int             DLY   = 3;
  localparam int             RATE  = 2;
  localparam int             DEPTH = 4;
  localparam logic [NB-1:0]  MASK  = 5'b11110;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic          cmd_ready = 1'b0;
  logic          tick_o, cmd_valid_o, cmd_rpt_o, overflow_o;
  logic [NB-1:0] btn_level_o;
  logic [2:0]    cmd_id_o;

  btn_cmd_scheduler #(
    .NUM_BTN     (NB),
    .DIV_W       (4),
    .REPEAT_MASK (MASK),
    .REPEAT_DLY  (DLY),
    .REPEAT_RATE (RATE),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw_i   (btn_raw),
    .tick_o      (tick_o),
    .btn_level_o (btn_level_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready),
    .cmd_id_o    (cmd_id_o),
    .cmd_rpt_o   (cmd_rpt_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model: behavioural, one update per clk edge
  int       m_div, m_owner, m_left, m_rr;
  bit       m_tick, m_tickd, m_ovf;
  bit [2:0] m_hist [NB];   // [2] newest sample, [1] debounced level
  bit       m_pend [NB];
  bit       m_prpt [NB];
  int       m_q[$];        // entry = rpt*16 + id

  task automatic model_reset();
    m_div = 0; m_tick = 0; m_tickd = 0; m_ovf = 0;
    m_owner = -1; m_left = 0; m_rr = 0;
    for (int i = 0; i < NB; i++) begin
      m_hist[i] = '0; m_pend[i] = 0; m_prpt[i] = 0;
    end
    m_q.delete();
  endtask

  task automatic model_step();
    bit press [NB];
    bit evt, merged;
    int rpt_id, newp, gnt, j;
    rpt_id = -1; newp = -1; gnt = -1;
    for (int i = 0; i < NB; i++) press[i] = m_tickd && m_hist[i][1] && !m_hist[i][0];
    if (m_tickd) begin
      for (int i = 0; i < NB; i++)
        if (newp < 0 && press[i] && MASK[i] && i != m_owner) newp = i;
      if (newp >= 0) begin
        m_owner = newp; m_left = DLY;
      end else if (m_owner >= 0 && !m_hist[m_owner][1]) begin
        m_owner = -1;
      end else if (m_owner >= 0) begin
        if (m_left == 1) begin rpt_id = m_owner; m_left = RATE; end
        else m_left--;
      end
    end
    if (m_q.size() < DEPTH)
      for (int k = 0; k < NB; k++) begin
        j = (m_rr + k) % NB;
        if (gnt < 0 && m_pend[j]) gnt = j;
      end
    if (m_q.size() > 0 && cmd_ready) void'(m_q.pop_front());
    if (gnt >= 0) begin
      m_q.push_back((m_prpt[gnt] ? 16 : 0) + gnt);
      m_rr = (gnt + 1) % NB;
    end
    for (int i = 0; i < NB; i++) begin
      evt    = press[i] || (rpt_id == i);
      merged = m_pend[i] && (gnt != i);
      if (evt) begin
        if (merged) m_ovf = 1;
        m_prpt[i] = press[i] ? 1'b0 : (merged ? m_prpt[i] : 1'b1);
        m_pend[i] = 1;
      end else if (gnt == i) begin
        m_pend[i] = 0;
      end
    end
    if (m_tick) for (int i = 0; i < NB; i++) m_hist[i] = {btn_raw[i], m_hist[i][2:1]};
    m_tickd = m_tick;
    m_tick  = (m_div == DIVP - 1);
    m_div   = (m_div + 1) % DIVP;
  endtask

  // ---------------- comparison helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [NB-1:0] lvl;
    for (int i = 0; i < NB; i++) lvl[i] = m_hist[i][1];
    chk("tick",     32'(tick_o),      32'(m_tick));
    chk("level",    32'(btn_level_o), 32'(lvl));
    chk("valid",    32'(cmd_valid_o), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("cmd_id",  32'(cmd_id_o),  32'(m_q[0] % 16));
      chk("cmd_rpt", 32'(cmd_rpt_o), 32'(m_q[0] / 16));
    end
    chk("overflow", 32'(overflow_o),  32'(m_ovf));
  endtask

  task automatic check_reset();
    chk("rst_tick",  32'(tick_o),      32'd0);
    chk("rst_level", 32'(btn_level_o), 32'd0);
    chk("rst_valid", 32'(cmd_valid_o), 32'd0);
    chk("rst_id",    32'(cmd_id_o),    32'd0);
    chk("rst_rpt",   32'(cmd_rpt_o),   32'd0);
    chk("rst_ovf",   32'(overflow_o),  32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // ---------------- stimulus
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    cmd_ready = 1'b1;

    // Bounce on the center button, then steady high: one fresh press, no repeats.
    btn_raw[BTN_CENTER] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (k % 3 == 2) btn_raw[BTN_CENTER] = ~btn_raw[BTN_CENTER];
    end
    btn_raw[BTN_CENTER] = 1'b1;
    run(8 * DIVP);
    btn_raw[BTN_CENTER] = 1'b0;
    run(3 * DIVP);

    // Single held press with repeats, then release.
    btn_raw[BTN_DOWN] = 1'b1;
    run(10 * DIVP);
    btn_raw[BTN_DOWN] = 1'b0;
    run(4 * DIVP);

    // Simultaneous rise of up, left, right.
    btn_raw[BTN_UP] = 1'b1; btn_raw[BTN_LEFT] = 1'b1; btn_raw[BTN_RIGHT] = 1'b1;
    run(2 * DIVP);
    btn_raw = '0;
    run(4 * DIVP);

    // Backpressure: FIFO fills, re-press of the pending button merges.
    cmd_ready = 1'b0;
    btn_raw = '1;
    run(3 * DIVP);
    btn_raw = '0;
    run(3 * DIVP);
    btn_raw = '1;
    run(3 * DIVP);
    cmd_ready = 1'b1;
    run(3 * DIVP);
    btn_raw = '0;
    run(4 * DIVP);

    // Ownership moves from up to right before the first repeat of up.
    btn_raw[BTN_UP] = 1'b1;
    run(DIVP);
    btn_raw[BTN_RIGHT] = 1'b1;
    run(8 * DIVP);
    btn_raw = '0;
    run(4 * DIVP);

    // Reset mid-repeat with commands queued.
    cmd_ready = 1'b0;
    btn_raw[BTN_LEFT] = 1'b1;
    run(7 * DIVP + 3);
    #2 rst = 1'b1;
    #1 check_reset();
    model_reset();
    btn_raw = '0;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    cmd_ready = 1'b1;
    run(4 * DIVP);

    // Randomised slow button activity with random consumer stalls.
    for (int k = 0; k < 1600; k++) begin
      if ($urandom_range(0, 29) == 0) btn_raw[$urandom_range(0, NB - 1)] ^= 1'b1;
      cmd_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    btn_raw = '0;
    cmd_ready = 1'b1;
    run(6 * DIVP);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
